aes_key_mem_mc: RTL
===================

# aes_key_mem_mc

Multi-context, word-serial AES key expansion memory supporting 128-, 192- and 256-bit keys. It expands one 32-bit key-schedule word per cycle into one of `2**CTX_W` independent key-schedule slots. It borrows SubWord from the shared external S-box through the `sboxw`/`new_sboxw` pair. The cipher datapath reads any completed slot combinationally by context and round while another slot is being expanded.

## Interface
- `CTX_W`, default 1: context index width; number of contexts `NUM_CTX = 2**CTX_W`.
- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `key` in 256: key, MSB-aligned. 128-bit uses [255:128], 192-bit uses [255:64], 256-bit uses [255:0]. Word w0 = key[255:224].
- `keylen` in 2: key length. 00 = 128 (Nk=4, Nr=10), 01 = 192 (Nk=6, Nr=12), 10 = 256 (Nk=8, Nr=14), 11 = illegal.
- `init` in 1: start-expansion request, sampled each cycle.
- `init_ctx` in CTX_W: target slot for `init`.
- `rd_ctx` in CTX_W: slot selected for read.
- `round` in 4: round-key index for read.
- `round_key` out 128: words 4·round..4·round+3 of slot `rd_ctx`, word 4·round in [127:96]. Combinational.
- `ctx_valid` out NUM_CTX: bit c = slot c holds a complete schedule.
- `busy` out 1: expansion in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse when an expansion completes.
- `err` out 1: one-cycle pulse on a rejected `init`.
- `sboxw` out 32: word to be substituted.
- `new_sboxw` in 32: SubWord(sboxw), combinational, valid in the same cycle.

## Operation
- Storage: NUM_CTX × 60 words × 32 bits. There is also an 8-word sliding window of the most recent words, a word counter `i` (6 bits), an `rcon` register (8 bits), and latched copies of `keylen`/`init_ctx`/`key`.
- FSM states: IDLE, GEN, DONE.
  - IDLE→GEN on an accepted `init`.
  - GEN→DONE after the last word is written.
  - DONE→IDLE unconditionally.
- `init` acceptance: `init`=1, state IDLE, `keylen`≠11. On acceptance the block latches the inputs, sets i=0 and rcon=0x01, and clears `ctx_valid[init_ctx]`.
- `init` rejection: `init`=1 with `keylen`=11, or `init`=1 in GEN/DONE.
  - `err` pulses the next cycle.
  - No other state changes; in-progress expansion is unaffected.
- GEN behaviour:
  - One word w[i] is written per cycle to slot[i]; i increments. Total words Nw = 4·(Nr+1) = 44 / 52 / 60.
  - i < Nk: w[i] = key word i.
  - i ≥ Nk, i mod Nk = 0: w[i] = w[i−Nk] ^ (rotl8(new_sboxw) ^ {rcon,24'h0}). Then rcon ← xtime(rcon), i.e. {rcon[6:0],0} ^ (0x1b & {8{rcon[7]}}).
  - Nk=8, i mod 8 = 4: w[i] = w[i−8] ^ new_sboxw.
  - Otherwise: w[i] = w[i−Nk] ^ w[i−1].
- `sboxw` = w[i−1] (window head) throughout GEN. It holds its last value otherwise. Final rcon used: 0x36 (128), 0x80 (192), 0x40 (256).
- DONE: sets `ctx_valid[ctx]` and pulses `done`.
- Read rules:
  - `round` > Nr of the slot's last latched keylen: `round_key` = 0.
  - Reading a slot with `ctx_valid`=0 returns current storage contents; consumers must gate on `ctx_valid`.
  - Reading other slots during GEN is unaffected.
- Re-init of a valid slot: its valid bit drops on acceptance; the old schedule is overwritten word by word.

## Timing
- Reset values:
  - `ctx_valid` = 0, `busy` = 0, `done` = 0, `err` = 0, `sboxw` = 0.
  - All storage = 0, so `round_key` = 0.
  - rcon = 0x01, state IDLE.
- `init` accepted at edge k:
  - `busy` = 1 from cycle k+1.
  - Words are written at edges k+1 … k+Nw.
  - DONE occupies cycle k+Nw+1: `done` = 1 and `ctx_valid` set at the edge ending that cycle.
  - Slot readable and `busy` = 0 from cycle k+Nw+2.
- Expansion latency: 45 / 53 / 61 cycles from the accept edge to `done`, for 128 / 192 / 256.
- Minimum init-to-init spacing: Nw+2 cycles. An `init` in the first IDLE cycle after DONE is accepted.
- `reset_n` low mid-expansion: immediate abort, full clear to reset values, no `done`.

## Test plan
- Reset → `ctx_valid`=0, `busy`=0, `round_key`=0 for all rd_ctx/round; assert reset mid-GEN → same, no `done`.
- AES-128, ctx 0: key 2b7e1516 28aed2a6 abf71588 09cf4f3c → `done` 45 cycles after accept; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; round 0 = key.
- AES-192, ctx 1: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → `done` after 53 cycles; round 12 = e98ba06f 448c773c 8ecc7204 01002202; round 13 reads 0.
- AES-256, ctx 0: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → `done` after 61 cycles; round 14 = fe4890d1 e6188d0b 046df344 706c631e.
- Ctx 1 holds the AES-192 schedule while AES-256 expands into ctx 0 → ctx 1 reads are stable throughout; `ctx_valid` = 10 during GEN, then 11.
- `init` during GEN, then `init` with `keylen`=11 in IDLE → `err` pulses once per request; schedules, `busy` and `done` timing unchanged.

Source files
------------

// File: rtl/aes_key_mem_mc.sv
// Multi-context word-serial AES key expansion memory (128/192/256-bit keys).
// One schedule word per cycle; completed slots are read combinationally by context and round.
`timescale 1ns/1ps

module aes_key_mem_mc #(
    parameter int CTX_W = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [255:0]           key,
    input  logic [1:0]             keylen,
    input  logic                   init,
    input  logic [CTX_W-1:0]       init_ctx,
    input  logic [CTX_W-1:0]       rd_ctx,
    input  logic [3:0]             round,
    output logic [127:0]           round_key,
    output logic [(2**CTX_W)-1:0]  ctx_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            sboxw,
    input  logic [31:0]            new_sboxw
);

    localparam int NUM_CTX = 2**CTX_W;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GEN = 2'd1, ST_DONE = 2'd2} state_t;

    function automatic logic [31:0] rotl8(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    logic [31:0]      r_mem [NUM_CTX][60];
    logic [31:0]      r_win [8];
    state_t           r_state;
    logic [5:0]       r_i;
    logic [2:0]       r_mod;
    logic [7:0]       r_rcon;
    logic [1:0]       r_keylen;
    logic [CTX_W-1:0] r_ctx;
    logic [255:0]     r_key;
    logic [1:0]       r_ctx_keylen [NUM_CTX];
    logic [NUM_CTX-1:0] r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic [3:0]       w_nk;
    logic [2:0]       w_nk_m1;
    logic [5:0]       w_nw;
    logic             w_past_key;
    logic             w_rcon_step;
    logic [31:0]      w_back;
    logic [31:0]      w_new;
    logic [31:0]      w_key_words [8];
    logic [3:0]       w_rd_nr;
    logic [5:0]       w_rd_base;

    assign w_accept    = init && (r_state == ST_IDLE) && (keylen != 2'b11);
    assign w_past_key  = (r_i >= {2'b00, w_nk});
    assign w_rcon_step = w_past_key && (r_mod == 3'd0);

    assign ctx_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign sboxw     = r_win[7];

    // Key-length dependent constants of the schedule being generated
    always_comb begin
        w_nk    = 4'd8;
        w_nk_m1 = 3'd7;
        w_nw    = 6'd60;
        w_back  = r_win[0];
        case (r_keylen)
            2'b00: begin w_nk = 4'd4; w_nk_m1 = 3'd3; w_nw = 6'd44; w_back = r_win[4]; end
            2'b01: begin w_nk = 4'd6; w_nk_m1 = 3'd5; w_nw = 6'd52; w_back = r_win[2]; end
            default: begin w_nk = 4'd8; w_nk_m1 = 3'd7; w_nw = 6'd60; w_back = r_win[0]; end
        endcase
    end

    // Next schedule word; r_win[7] is w[i-1], r_win[8-Nk] is w[i-Nk]
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_key_words[j] = r_key[255 - 32*j -: 32];
        end
        w_new = 32'h0;
        if (!w_past_key) begin
            w_new = w_key_words[r_i[2:0]];
        end else if (r_mod == 3'd0) begin
            w_new = w_back ^ rotl8(new_sboxw) ^ {r_rcon, 24'h0};
        end else if ((r_keylen == 2'b10) && (r_mod == 3'd4)) begin
            w_new = w_back ^ new_sboxw;
        end else begin
            w_new = w_back ^ r_win[7];
        end
    end

    // Expansion FSM with its counters, latched request and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_i      <= 6'd0;
            r_mod    <= 3'd0;
            r_rcon   <= 8'h01;
            r_keylen <= 2'b00;
            r_ctx    <= '0;
            r_key    <= 256'h0;
            r_valid  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                r_win[j] <= 32'h0;
            end
            for (int c = 0; c < NUM_CTX; c++) begin
                r_ctx_keylen[c] <= 2'b10;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= init && !w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_keylen               <= keylen;
                        r_ctx                  <= init_ctx;
                        r_key                  <= key;
                        r_i                    <= 6'd0;
                        r_mod                  <= 3'd0;
                        r_rcon                 <= 8'h01;
                        r_valid[init_ctx]      <= 1'b0;
                        r_ctx_keylen[init_ctx] <= keylen;
                        r_busy                 <= 1'b1;
                        r_state                <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    for (int j = 0; j < 7; j++) begin
                        r_win[j] <= r_win[j+1];
                    end
                    r_win[7] <= w_new;
                    r_i      <= r_i + 6'd1;
                    r_mod    <= (r_mod == w_nk_m1) ? 3'd0 : r_mod + 3'd1;
                    if (w_rcon_step) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (r_i == w_nw - 6'd1) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_valid[r_ctx] <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Schedule storage: one word written per GEN cycle into the latched slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                for (int w = 0; w < 60; w++) begin
                    r_mem[c][w] <= 32'h0;
                end
            end
        end else if (r_state == ST_GEN) begin
            r_mem[r_ctx][r_i] <= w_new;
        end
    end

    // Combinational round-key read; rounds beyond the slot's Nr read as zero
    always_comb begin
        case (r_ctx_keylen[rd_ctx])
            2'b00:   w_rd_nr = 4'd10;
            2'b01:   w_rd_nr = 4'd12;
            default: w_rd_nr = 4'd14;
        endcase
        w_rd_base = (round > 4'd14) ? 6'd56 : {round, 2'b00};
        if (round > w_rd_nr) begin
            round_key = 128'h0;
        end else begin
            round_key = {r_mem[rd_ctx][w_rd_base],
                         r_mem[rd_ctx][w_rd_base + 6'd1],
                         r_mem[rd_ctx][w_rd_base + 6'd2],
                         r_mem[rd_ctx][w_rd_base + 6'd3]};
        end
    end

endmodule
